// File: rtl/stim_pkg.sv
// Shared state encoding and default per-vector hold period for the stimulus generator.
// Generated benches import this so they agree with the generator on vector timing.
package stim_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam int DEFAULT_HOLD = 10;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DRIVE = ST_DRIVE,
        S_WAIT  = ST_WAIT,
        S_FIN   = ST_FIN
    } stim_state_t;

endpackage

// File: rtl/hold_timer.sv
// Hold-window counter: expire is high while cnt == HOLD-1; counts on en, clears on clr.
// Latency: expire asserts HOLD-1 enabled clocks after clr; holds (saturates) until cleared.
module hold_timer
    import stim_pkg::*;
#(
    parameter int HOLD = DEFAULT_HOLD
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

    logic [CW-1:0] cnt;

    // Saturating at the terminal count keeps expire asserted while the owner waits.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire = (cnt == LAST_CNT);

endmodule

// File: rtl/exhaustive_stim_gen.sv
// Walks all 2^WIDTH vectors in binary order, each held HOLD clocks; first VALID 1 clock after START.
// Backpressure: at the end of each hold window the vector is frozen until READY is seen high.
module exhaustive_stim_gen
    import stim_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int HOLD  = DEFAULT_HOLD
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic             READY,
    output logic [WIDTH-1:0] VEC,
    output logic             VALID,
    output logic             LAST,
    output logic             BUSY,
    output logic             DONE
);

    stim_state_t      state, state_nxt;
    logic [WIDTH-1:0] vec_nxt;
    logic             cnt_clr;
    logic             cnt_en;
    logic             expire;
    logic             vec_top;
    logic             advance;

    hold_timer #(.HOLD(HOLD)) u_hold_timer (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expire (expire)
    );

    assign vec_top = (VEC == '1);
    assign advance = READY && (((state == S_DRIVE) && expire) || (state == S_WAIT));

    always_comb begin
        state_nxt = state;
        vec_nxt   = VEC;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        if (ABORT) begin
            state_nxt = S_IDLE;
            vec_nxt   = '0;
            cnt_clr   = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_FIN: begin
                    if (START) begin
                        state_nxt = S_DRIVE;
                        vec_nxt   = '0;
                        cnt_clr   = 1'b1;
                    end
                end
                S_DRIVE: begin
                    cnt_en = 1'b1;
                    if (expire && !READY) begin
                        state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    state_nxt = S_WAIT;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
            // All-ones never increments: the final window hands over to FIN instead.
            if (advance) begin
                cnt_clr = 1'b1;
                if (vec_top) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_DRIVE;
                    vec_nxt   = VEC + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            VEC   <= '0;
            VALID <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            state <= state_nxt;
            VEC   <= vec_nxt;
            VALID <= (state_nxt == S_DRIVE) || (state_nxt == S_WAIT);
            BUSY  <= (state_nxt == S_DRIVE) || (state_nxt == S_WAIT);
            DONE  <= (state_nxt == S_FIN);
        end
    end

    assign LAST = VALID && vec_top;

endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Bench for exhaustive_stim_gen: WIDTH=3/HOLD=10 instance plus a WIDTH=2/HOLD=1 instance.
// Expected vectors are queued when a sweep is started and popped as the DUT presents them.
module tb_exhaustive_stim_gen;

    localparam int HOLD_T = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       ready = 1'b1;
    logic [2:0] vec;
    logic       valid, last, busy, done;

    logic       start1 = 1'b0;
    logic       abort1 = 1'b0;
    logic       ready1 = 1'b1;
    logic [1:0] vec1;
    logic       valid1, last1, busy1, done1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_q[$];
    logic [1:0] exp_q1[$];

    always #5 clk = ~clk;

    exhaustive_stim_gen #(.WIDTH(3), .HOLD(HOLD_T)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .ABORT(abort), .READY(ready),
        .VEC(vec), .VALID(valid), .LAST(last), .BUSY(busy), .DONE(done)
    );

    exhaustive_stim_gen #(.WIDTH(2), .HOLD(1)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .ABORT(abort1), .READY(ready1),
        .VEC(vec1), .VALID(valid1), .LAST(last1), .BUSY(busy1), .DONE(done1)
    );

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_vec(input logic [2:0] v, input string name);
        int k = 0;
        while (!(valid === 1'b1 && vec === v) && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k >= 200) begin
            n_fail++;
            $display("FAIL %s wait_vec%0d: no VALID vector %0d within 200 clocks (vec=%0d valid=%b)",
                     name, v, v, vec, valid);
        end
    endtask

    task automatic run_sweep(input bit bp, input string name);
        int         cyc = 0;
        int         hold = 0;
        int         exp_hold;
        int         exp_cyc;
        bit         first = 1'b1;
        logic [2:0] prev = 3'd0;
        logic [2:0] exp_v;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
        ready = 1'b1;
        pulse_start();
        while (done !== 1'b1 && cyc < 300) begin
            if (valid === 1'b1) begin
                if (first || vec !== prev) begin
                    if (!first) begin
                        exp_hold = (bp && prev == 3'd3) ? 25 : HOLD_T;
                        n_checks++;
                        if (hold != exp_hold) begin
                            n_fail++;
                            $display("FAIL %s hold_len vec=%0d: got %0d clocks, expected %0d",
                                     name, prev, hold, exp_hold);
                        end
                    end
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_vec: got vec=%0d, expected no more vectors", name, vec);
                    end else begin
                        exp_v = exp_q.pop_front();
                        if (vec !== exp_v) begin
                            n_fail++;
                            $display("FAIL %s vec_order: got %0d, expected %0d", name, vec, exp_v);
                        end
                    end
                    prev  = vec;
                    hold  = 0;
                    first = 1'b0;
                end
                hold++;
                n_checks++;
                if (last !== (vec == 3'd7)) begin
                    n_fail++;
                    $display("FAIL %s last: got %b with vec=%0d, expected %b", name, last, vec, (vec == 3'd7));
                end
                if (bp && vec == 3'd3 && hold == 5)  ready = 1'b0;
                if (bp && vec == 3'd3 && hold == 25) ready = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        ready = 1'b1;
        exp_cyc = bp ? 95 : 80;
        n_checks++;
        if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s done_time: DONE after %0d clocks, expected %0d", name, cyc, exp_cyc);
        end
        n_checks++;
        if (hold != HOLD_T || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s tail: last hold %0d (exp %0d), %0d vectors never seen (exp 0)",
                     name, hold, HOLD_T, exp_q.size());
        end
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL %s fin_flags: valid=%b busy=%b last=%b, expected 0 0 0", name, valid, busy, last);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (vec !== 3'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: vec=%0d valid=%b busy=%b done=%b last=%b, expected all 0",
                     vec, valid, busy, done, last);
        end
        n_checks++;
        if (vec1 !== 2'd0 || valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state_h1: vec=%0d valid=%b busy=%b done=%b, expected all 0",
                     vec1, valid1, busy1, done1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_sweep();
        run_sweep(1'b0, "basic");
    endtask

    task automatic test_backpressure();
        run_sweep(1'b1, "backpressure");
    endtask

    task automatic test_hold1();
        logic [1:0] e;
        exp_q1.delete();
        for (int i = 0; i < 4; i++) exp_q1.push_back(2'(i));
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e = exp_q1.pop_front();
            n_checks++;
            if (vec1 !== e || valid1 !== 1'b1) begin
                n_fail++;
                $display("FAIL hold1_vec step%0d: vec=%0d valid=%b, expected vec=%0d valid=1",
                         i, vec1, valid1, e);
            end
            @(negedge clk);
        end
        n_checks++;
        if (done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b0 || vec1 !== 2'd3) begin
            n_fail++;
            $display("FAIL hold1_done: done=%b valid=%b busy=%b vec=%0d, expected 1 0 0 3",
                     done1, valid1, busy1, vec1);
        end
    endtask

    task automatic test_async_reset();
        pulse_start();
        wait_vec(3'd5, "async_reset");
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (vec !== 3'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_now: vec=%0d valid=%b busy=%b done=%b, expected all 0",
                     vec, valid, busy, done);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_idle: valid=%b done=%b, expected 0 0", valid, done);
        end
        run_sweep(1'b0, "post_reset");
    endtask

    task automatic test_abort();
        pulse_start();
        wait_vec(3'd2, "abort");
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        n_checks++;
        if (vec !== 3'd0 || valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: vec=%0d valid=%b busy=%b done=%b, expected all 0",
                     vec, valid, busy, done);
        end
        @(negedge clk);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (valid !== 1'b0 || busy !== 1'b0 || vec !== 3'd0) begin
                n_fail++;
                $display("FAIL abort_beats_start c%0d: valid=%b busy=%b vec=%0d, expected 0 0 0",
                         i, valid, busy, vec);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart();
        int k = 1;
        pulse_start();
        wait_vec(3'd4, "restart");
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_checks++;
        if (vec !== 3'd4 || valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_busy: vec=%0d valid=%b busy=%b, expected 4 1 1", vec, valid, busy);
        end
        while (done !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != 40) begin
            n_fail++;
            $display("FAIL busy_start_timing: DONE %0d clocks after vec 4 began, expected 40", k);
        end
        n_checks++;
        if (vec !== 3'd7 || valid !== 1'b0 || last !== 1'b0) begin
            n_fail++;
            $display("FAIL fin_hold: vec=%0d valid=%b last=%b, expected 7 0 0", vec, valid, last);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_level: done=%b, expected 1", done);
        end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || vec !== 3'd0 || valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_fin: done=%b vec=%0d valid=%b busy=%b, expected 0 0 1 1",
                     done, vec, valid, busy);
        end
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_sweep();
        test_backpressure();
        test_hold1();
        test_async_reset();
        test_abort();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
